// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link constants.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int unsigned UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte holding register out with valid/ready.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
);

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  // Receiver drives the byte and status; the consumer drives the line and ready.
  modport master (
    input  rx, ready,
    output data, valid, frame_err, overrun, parity_err
  );

  modport slave (
    output rx, ready,
    input  data, valid, frame_err, overrun, parity_err
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous input; clr presets both flops to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the raw input and let it settle through a second stage.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 when UART_RX_PARITY_EN is defined), LSB first,
// mid-bit sampling, single-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic      clk,
  input  logic      clr,
  uart_rx_if.master bus
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       r_state, w_state;
  logic [TICK_W-1:0]    r_tick, w_tick;
  logic [IDX_W-1:0]     r_idx, w_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [DATA_BITS-1:0] r_data, w_data;
  logic                 r_valid, w_valid;
  logic                 r_frame_err, w_frame_err;
  logic                 r_overrun, w_overrun;
`ifdef UART_RX_PARITY_EN
  logic                 r_par, w_par;
  logic                 r_parity_err, w_parity_err;
`endif
  logic                 w_rx_s;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .clr (clr),
    .i_d (bus.rx),
    .o_q (w_rx_s)
  );

  // Next-state, datapath and output pulse decode.
  always_comb begin
    w_state     = r_state;
    w_tick      = r_tick;
    w_idx       = r_idx;
    w_shift     = r_shift;
    w_data      = r_data;
    w_valid     = r_valid & ~bus.ready;
    w_frame_err = 1'b0;
    w_overrun   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par        = r_par;
    w_parity_err = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state = START;
          w_tick  = '0;
        end
      end

      START: begin
        if (r_tick == TICK_HALF) begin
          w_tick = '0;
          if (!w_rx_s) begin
            w_state = DATA;
            w_idx   = '0;
          end else begin
            w_state = IDLE;
          end
        end else begin
          w_tick = r_tick + TICK_W'(1);
        end
      end

      DATA: begin
        if (r_tick == TICK_LAST) begin
          w_tick  = '0;
          w_shift = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_idx   = r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state = PARITY;
`else
            w_state = STOP;
`endif
          end
        end else begin
          w_tick = r_tick + TICK_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_tick == TICK_LAST) begin
          w_tick  = '0;
          w_par   = w_rx_s;
          w_state = STOP;
        end else begin
          w_tick = r_tick + TICK_W'(1);
        end
      end
`endif

      STOP: begin
        if (r_tick == TICK_LAST) begin
          w_tick  = '0;
          w_state = IDLE;
          if (!w_rx_s) begin
            w_frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{r_shift, r_par}) begin
            w_parity_err = 1'b1;
`endif
          end else if (r_valid && !bus.ready) begin
            w_overrun = 1'b1;
          end else begin
            // A same-cycle handshake frees the register, so the new byte lands.
            w_data  = r_shift;
            w_valid = 1'b1;
          end
        end else begin
          w_tick = r_tick + TICK_W'(1);
        end
      end

      default: w_state = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_tick      <= w_tick;
      r_idx       <= w_idx;
      r_shift     <= w_shift;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
`ifdef UART_RX_PARITY_EN
      r_par        <= w_par;
      r_parity_err <= w_parity_err;
`endif
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed table, multi-cycle corner
// sequences and a randomized frame stream against a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = 16;
  localparam int unsigned DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PB  = 1;
`else
  localparam int unsigned PB  = 0;
`endif
  localparam int unsigned FBITS = DB + PB + 2;
  // 2 sync flops + 1 cycle to leave IDLE + half bit + full bits through stop
  localparam int unsigned LAT   = 3 + CPB / 2 + CPB * (DB + 1 + PB);

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       pg;
    int         bytes;
    int         ferr;
    int         perr;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b1;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0;
  int s_ferr, s_ovr, s_perr;
  int e_ferr, e_perr;
  logic p_ferr = 1'b0, p_ovr = 1'b0, p_perr = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_data;
  vec_t vq[$];
  int lat_first, lat_cnt;
  logic [7:0] rb;
  logic rstop, rpg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer side: collect accepted bytes and count status pulses.
  always @(negedge clk) begin
    if (!clr) begin
      if (bus.valid && bus.ready) got_q.push_back(bus.data);
      if (bus.frame_err) begin
        n_ferr++;
        chk("frame_err_width", 32'(p_ferr), 0);
      end
      if (bus.overrun) begin
        n_ovr++;
        chk("overrun_width", 32'(p_ovr), 0);
      end
      if (bus.parity_err) begin
        n_perr++;
        chk("parity_err_width", 32'(p_perr), 0);
      end
    end
    p_ferr = bus.frame_err;
    p_ovr  = bus.overrun;
    p_perr = bus.parity_err;
  end

  function automatic logic [15:0] make_frame(input logic [7:0] b, input logic stop,
                                             input logic pg);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < int'(DB); i++) f[1 + i] = b[i];
    if (PB != 0) f[DB + 1] = pg ? ^b : ~^b;
    f[FBITS - 1] = stop;
    return f;
  endfunction

  // Drive one frame; returns one edge before the stop bit ends so frames can abut.
  task automatic send_bits(input logic [15:0] f);
    @(posedge clk); #1 bus.rx = f[0];
    for (int i = 1; i < int'(FBITS); i++) begin
      repeat (CPB) @(posedge clk);
      #1 bus.rx = f[i];
    end
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1 bus.rx = 1'b1;
    end
  endtask

  task automatic snap();
    s_ferr = n_ferr;
    s_ovr  = n_ovr;
    s_perr = n_perr;
    got_q.delete();
  endtask

  // Frame-level outcome with ready held high.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic pg);
    if (!stop) e_ferr++;
    else if (PB != 0 && !pg) e_perr++;
    else begin
      exp_q.push_back(b);
      model_data = b;
    end
  endtask

  initial begin
    bus.rx    = 1'b1;
    bus.ready = 1'b1;
    model_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_frame_err", 32'(bus.frame_err), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_parity_err", 32'(bus.parity_err), 0);
    clr = 1'b0;
    idle(4);

    // 0xA5: latency and single-cycle valid
    snap();
    fork
      send_bits(make_frame(8'hA5, 1'b1, 1'b1));
      begin
        lat_first = -1;
        lat_cnt   = 0;
        @(posedge clk);
        for (int k = 1; k <= int'(LAT) + 4; k++) begin
          @(posedge clk); #1;
          if (bus.valid) begin
            lat_cnt++;
            if (lat_first < 0) lat_first = k;
          end
        end
      end
    join
    chk("a5_valid_latency", 32'(lat_first), LAT);
    chk("a5_valid_width", 32'(lat_cnt), 1);
    idle(2 * CPB);
    model_data = 8'hA5;
    chk("a5_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) chk("a5_data", 32'(got_q[0]), 32'h A5);
    chk("a5_no_ferr", 32'(n_ferr - s_ferr), 0);
    chk("a5_no_perr", 32'(n_perr - s_perr), 0);

    // Back-to-back 0x00 then 0xFF
    snap();
    send_bits(make_frame(8'h00, 1'b1, 1'b1));
    send_bits(make_frame(8'hFF, 1'b1, 1'b1));
    idle(2 * CPB);
    model_data = 8'hFF;
    chk("b2b_count", 32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first", 32'(got_q[0]), 32'h00);
      chk("b2b_second", 32'(got_q[1]), 32'hFF);
    end

    // False start: 4 low cycles, then 0x5A
    snap();
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.rx = 1'b1;
    idle(2 * CPB);
    chk("false_start_count", 32'(got_q.size()), 0);
    chk("false_start_ferr", 32'(n_ferr - s_ferr), 0);
    chk("false_start_valid", 32'(bus.valid), 0);
    send_bits(make_frame(8'h5A, 1'b1, 1'b1));
    idle(2 * CPB);
    model_data = 8'h5A;
    chk("after_false_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) chk("after_false_data", 32'(got_q[0]), 32'h5A);

    // Directed table
    vq.push_back('{8'h3C, 1'b0, 1'b1, 0, 1, 0});
    vq.push_back('{8'h81, 1'b1, 1'b1, 1, 0, 0});
    vq.push_back('{8'h7E, 1'b1, 1'b1, 1, 0, 0});
    vq.push_back('{8'hC0, 1'b0, 1'b1, 0, 1, 0});
    vq.push_back('{8'h01, 1'b1, 1'b1, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vq.push_back('{8'h07, 1'b1, 1'b0, 0, 0, 1});
    vq.push_back('{8'h07, 1'b1, 1'b1, 1, 0, 0});
`endif
    for (int i = 0; i < vq.size(); i++) begin
      snap();
      send_bits(make_frame(vq[i].b, vq[i].stop, vq[i].pg));
      idle(2 * CPB);
      if (vq[i].bytes != 0) model_data = vq[i].b;
      chk($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'(vq[i].bytes));
      if (vq[i].bytes != 0 && got_q.size() > 0)
        chk($sformatf("vec%0d_byte", i), 32'(got_q[0]), 32'(vq[i].b));
      chk($sformatf("vec%0d_ferr", i), 32'(n_ferr - s_ferr), 32'(vq[i].ferr));
      chk($sformatf("vec%0d_perr", i), 32'(n_perr - s_perr), 32'(vq[i].perr));
      chk($sformatf("vec%0d_data_reg", i), 32'(bus.data), 32'(model_data));
      chk($sformatf("vec%0d_valid", i), 32'(bus.valid), 0);
    end

    // Overrun: ready low, 0x11 then 0x22
    snap();
    bus.ready = 1'b0;
    send_bits(make_frame(8'h11, 1'b1, 1'b1));
    idle(3);
    send_bits(make_frame(8'h22, 1'b1, 1'b1));
    idle(2 * CPB);
    chk("ovr_valid_held", 32'(bus.valid), 1);
    chk("ovr_data_held", 32'(bus.data), 32'h11);
    chk("ovr_pulses", 32'(n_ovr - s_ovr), 1);
    bus.ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr_valid_drop", 32'(bus.valid), 0);
    chk("ovr_data_kept", 32'(bus.data), 32'h11);
    chk("ovr_accepted", 32'(got_q.size()), 1);
    if (got_q.size() > 0) chk("ovr_accepted_byte", 32'(got_q[0]), 32'h11);
    model_data = 8'h11;

    // Randomized stream
    snap();
    exp_q.delete();
    e_ferr = 0;
    e_perr = 0;
    for (int k = 0; k < 30; k++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      rpg   = (PB != 0) ? ($urandom_range(0, 5) != 0) : 1'b1;
      model_frame(rb, rstop, rpg);
      send_bits(make_frame(rb, rstop, rpg));
      if (!rstop) idle(CPB);
      else idle(int'($urandom_range(0, 3)));
    end
    idle(2 * CPB);
    chk("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("rnd_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("rnd_ferr", 32'(n_ferr - s_ferr), 32'(e_ferr));
    chk("rnd_perr", 32'(n_perr - s_perr), 32'(e_perr));
    chk("rnd_ovr", 32'(n_ovr - s_ovr), 0);
    chk("rnd_data_reg", 32'(bus.data), 32'(model_data));

    // clr in the middle of data bit 4, then 0xC3
    snap();
    fork
      send_bits(make_frame(8'hF1, 1'b1, 1'b1));
      begin
        @(posedge clk);
        repeat (3 + CPB / 2 + CPB * 4 + CPB / 2) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk("clr_valid", 32'(bus.valid), 0);
        chk("clr_data", 32'(bus.data), 0);
      end
    join
    idle(2 * CPB);
    model_data = 8'h00;
    chk("clr_no_byte", 32'(got_q.size()), 0);
    chk("clr_no_ferr", 32'(n_ferr - s_ferr), 0);
    chk("clr_no_perr", 32'(n_perr - s_perr), 0);
    chk("clr_data_after", 32'(bus.data), 32'(model_data));
    snap();
    send_bits(make_frame(8'hC3, 1'b1, 1'b1));
    idle(2 * CPB);
    chk("c3_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) chk("c3_data", 32'(got_q[0]), 32'hC3);
    chk("c3_no_ferr", 32'(n_ferr - s_ferr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
